hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, the maximum data-memory wait cycles before an error is flagged.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports id_rs1_addr, id_rs2_addr  in  5  source registers of the instruction in ID.
REQ-005 SHALL have ports ex_rs1_addr, ex_rs2_addr, ex_rd_addr  in  5  register fields of the instruction in EX.
REQ-006 SHALL have port ex_mem_read  in  1  the instruction in EX is a load.
REQ-007 SHALL have ports ex_br_taken  in  1  and ex_br_target  in  32, the branch-condition outcome and the target, including JAL/JALR.
REQ-008 SHALL have ports mem_rd_addr  in  5  and mem_reg_wr  in  1 for the MEM stage, and wb_rd_addr  in  5  and wb_reg_wr  in  1 for the WB stage.
REQ-009 SHALL have ports dmem_req  in  1  and dmem_ready  in  1, the data-memory request/ready handshake.
REQ-010 SHALL have ports fwd_a_sel, fwd_b_sel  out  2  forwarding muxes for the EX operands.
REQ-011 SHALL have ports pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1  pipeline-register hold enables.
REQ-012 SHALL have ports if_id_flush, id_ex_flush  out  1  bubble insertion.
REQ-013 SHALL have ports pc_redirect  out  1  and redirect_pc  out  32, the PC override.
REQ-014 SHALL have ports stall_cnt, flush_cnt  out  32  saturating performance counters, and bus_err  out  1  a sticky timeout flag.

Function
REQ-015 SHALL drive fwd_x_sel as follows: 01 (MEM) if mem_reg_wr and mem_rd_addr equals ex_rsx_addr and is nonzero; otherwise 10 (WB) under the same condition on WB; otherwise 00. MEM takes priority over WB.
REQ-016 SHALL detect load-use combinationally: ex_mem_read, ex_rd_addr≠0, and ex_rd_addr equal to id_rs1_addr or id_rs2_addr. The response is pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly that cycle.
REQ-017 SHALL treat mem_wait = dmem_req & ~dmem_ready. While in RUN with mem_wait, or in MEM_WAIT, it asserts all four stall outputs and suppresses every flush and redirect.
REQ-018 SHALL, on ex_br_taken with no memory stall, assert pc_redirect=1, redirect_pc=ex_br_target, if_id_flush=1, id_ex_flush=1 in the same cycle. The branch overrides the load-use stall: pc_stall=0 and if_id_stall=0.
REQ-019 SHALL hold redirect_pc at 0 whenever pc_redirect=0.
REQ-020 SHALL implement an FSM with states RUN, MEM_WAIT, ERROR:
  - RUN->MEM_WAIT on mem_wait.
  - MEM_WAIT->RUN on dmem_ready.
  - MEM_WAIT->ERROR when the wait counter reaches MEM_TIMEOUT.
  - ERROR is terminal until reset.
REQ-021 SHALL clear the wait counter on entry to MEM_WAIT and increment it each cycle in MEM_WAIT. dmem_ready in the same cycle as the timeout match wins, and the FSM returns to RUN.
REQ-022 SHALL, in ERROR, assert bus_err=1 and all four stall outputs permanently, with no flush or redirect.
REQ-023 SHALL increment stall_cnt in every cycle in which pc_stall=1, saturating at 0xFFFF_FFFF.
REQ-024 SHALL increment flush_cnt in every cycle in which pc_redirect=1, saturating at 0xFFFF_FFFF.
REQ-025 SHALL have combinational control outputs except bus_err and the counters. Latency from hazard to control is zero cycles.

Reset
REQ-026 SHALL, on rst, asynchronously force: state RUN, wait counter 0, stall_cnt 0, flush_cnt 0, bus_err 0.
REQ-027 SHALL, while rst is high, drive all stall, flush and redirect outputs to 0, fwd_x_sel to 00 and redirect_pc to 0.
REQ-028 SHALL, on rst asserted mid-wait or in ERROR, return to RUN with no residual stall in the first cycle after release.

Structure
REQ-029 SHALL place the forwarding-select constants (FWD_NONE=00, FWD_MEM=01, FWD_WB=10) and the FSM state enum in the shared package hazard_pkg.
REQ-030 SHALL implement both counters as instances of one sub-module, sat_counter, which is 32-bit with inputs clk, rst and inc.

Verification
REQ-031 SHALL cover forwarding: MEM writes x5, WB writes x5, ex_rs1_addr=5 -> fwd_a_sel=01. Then with rd=0 on both -> fwd_a_sel=00.
REQ-032 SHALL cover load-use: a load to x7 in EX with id_rs2_addr=7 -> one cycle of pc_stall=1, id_ex_flush=1, stall_cnt=1.
REQ-033 SHALL cover branch: ex_br_taken=1, target 0x0000_0100 -> pc_redirect=1, redirect_pc=0x100, both flushes=1, flush_cnt=1. The same stimulus with a simultaneous load-use -> pc_stall=0.
REQ-034 SHALL cover memory wait: dmem_req=1, dmem_ready low for 3 cycles -> four stalls held for those cycles and a pending branch redirected only in the cycle after dmem_ready.
REQ-035 SHALL cover timeout: MEM_TIMEOUT=4 with dmem_ready never high -> bus_err=1 after 5 wait cycles. Stalls stay high until rst, which clears bus_err and the counters.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forwarding constants, FSM states and forwarding helper
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } hz_state_e;

  // Youngest producer wins: MEM is checked before WB; x0 never forwards.
  function automatic logic [1:0] fwd_select(
    input logic       mem_wr,
    input logic [4:0] mem_rd,
    input logic       wb_wr,
    input logic [4:0] wb_rd,
    input logic [4:0] rs
  );
    if (mem_wr && (mem_rd != 5'd0) && (mem_rd == rs)) return FWD_MEM;
    if (wb_wr && (wb_rd != 5'd0) && (wb_rd == rs)) return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - 32-bit saturating event counter
module sat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: step on inc, hold once all ones.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) count_d = count_q + 32'd1;
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= 32'd0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard unit: forwarding, stalls, flushes, redirect, memory timeout
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  ex_rs1_addr,
  input  logic [4:0]  ex_rs2_addr,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_mem_read,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_target,
  input  logic [4:0]  mem_rd_addr,
  input  logic        mem_reg_wr,
  input  logic [4:0]  wb_rd_addr,
  input  logic        wb_reg_wr,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic        bus_err
);

  localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MEM_TIMEOUT);

  hz_state_e     state_q;
  logic [WW-1:0] wait_q;
  logic          bus_err_q;

  logic mem_wait;
  logic mem_stall;
  logic load_use;

  assign mem_wait  = dmem_req & ~dmem_ready;
  // Outside RUN the pipeline is frozen regardless of the current handshake.
  assign mem_stall = (state_q == ST_RUN) ? mem_wait : 1'b1;
  assign load_use  = ex_mem_read && (ex_rd_addr != 5'd0) &&
                     ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));

  // Zero-latency control: memory freeze > taken branch > load-use bubble.
  always_comb begin
    fwd_a_sel    = FWD_NONE;
    fwd_b_sel    = FWD_NONE;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pc_redirect  = 1'b0;
    redirect_pc  = 32'd0;
    if (!rst) begin
      fwd_a_sel = fwd_select(mem_reg_wr, mem_rd_addr, wb_reg_wr, wb_rd_addr, ex_rs1_addr);
      fwd_b_sel = fwd_select(mem_reg_wr, mem_rd_addr, wb_reg_wr, wb_rd_addr, ex_rs2_addr);
      if (mem_stall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
      end else if (ex_br_taken) begin
        pc_redirect = 1'b1;
        redirect_pc = ex_br_target;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Data-memory wait tracker; ERROR is sticky until reset, ready wins over timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_wait) begin
            state_q <= ST_MEM_WAIT;
            wait_q  <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            state_q <= ST_RUN;
          end else if (wait_q == WAIT_LIMIT) begin
            state_q   <= ST_ERROR;
            bus_err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_ERROR: bus_err_q <= 1'b1;
        default:  state_q   <= ST_RUN;
      endcase
    end
  end

  assign bus_err = bus_err_q;

  sat_counter u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_stall),
    .count (stall_cnt)
  );

  sat_counter u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_redirect),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic        ex_mem_read, ex_br_taken;
  logic [31:0] ex_br_target;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_reg_wr, wb_reg_wr;
  logic        dmem_req, dmem_ready;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic        if_id_flush, id_ex_flush, pc_redirect;
  logic [31:0] redirect_pc, stall_cnt, flush_cnt;
  logic        bus_err;

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .mem_rd_addr(mem_rd_addr), .mem_reg_wr(mem_reg_wr),
    .wb_rd_addr(wb_rd_addr), .wb_reg_wr(wb_reg_wr),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Reference model: 0 = running, 1 = waiting on memory, 2 = bus error.
  int     m_mode = 0;
  int     m_wait = 0;
  longint m_sc   = 0;
  longint m_fc   = 0;
  bit     m_berr = 0;

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (mem_reg_wr && mem_rd_addr == rs) return 2'b01;
    if (wb_reg_wr && wb_rd_addr == rs) return 2'b10;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    logic [1:0]  ea, eb;
    logic        eps, eifs, eids, ems, eiff, eidf, ered;
    logic [31:0] epc;
    bit          frozen, lu;
    ea = 0; eb = 0; eps = 0; eifs = 0; eids = 0; ems = 0; eiff = 0; eidf = 0; ered = 0; epc = 0;
    if (rst) begin
      m_mode = 0; m_wait = 0; m_sc = 0; m_fc = 0; m_berr = 0;
    end else begin
      ea = exp_fwd(ex_rs1_addr);
      eb = exp_fwd(ex_rs2_addr);
      frozen = (m_mode != 0) || (dmem_req && !dmem_ready);
      lu = ex_mem_read && ex_rd_addr != 0 && (ex_rd_addr == id_rs1_addr || ex_rd_addr == id_rs2_addr);
      if (frozen) begin
        eps = 1; eifs = 1; eids = 1; ems = 1;
      end else if (ex_br_taken) begin
        ered = 1; epc = ex_br_target; eiff = 1; eidf = 1;
      end else if (lu) begin
        eps = 1; eifs = 1; eidf = 1;
      end
    end
    chk("fwd_a_sel", 32'(fwd_a_sel), 32'(ea));
    chk("fwd_b_sel", 32'(fwd_b_sel), 32'(eb));
    chk("pc_stall", 32'(pc_stall), 32'(eps));
    chk("if_id_stall", 32'(if_id_stall), 32'(eifs));
    chk("id_ex_stall", 32'(id_ex_stall), 32'(eids));
    chk("ex_mem_stall", 32'(ex_mem_stall), 32'(ems));
    chk("if_id_flush", 32'(if_id_flush), 32'(eiff));
    chk("id_ex_flush", 32'(id_ex_flush), 32'(eidf));
    chk("pc_redirect", 32'(pc_redirect), 32'(ered));
    chk("redirect_pc", redirect_pc, epc);
    chk("stall_cnt", stall_cnt, 32'(m_sc));
    chk("flush_cnt", flush_cnt, 32'(m_fc));
    chk("bus_err", 32'(bus_err), 32'(m_berr));
    if (!rst) begin
      if (eps && m_sc < 64'hFFFF_FFFF) m_sc++;
      if (ered && m_fc < 64'hFFFF_FFFF) m_fc++;
      case (m_mode)
        0: if (dmem_req && !dmem_ready) begin m_mode = 1; m_wait = 0; end
        1: begin
          if (dmem_ready) m_mode = 0;
          else if (m_wait == TO) begin m_mode = 2; m_berr = 1; end
          else m_wait++;
        end
        default: ;
      endcase
    end
  end

  task automatic clear_in;
    id_rs1_addr = 0; id_rs2_addr = 0; ex_rs1_addr = 0; ex_rs2_addr = 0; ex_rd_addr = 0;
    ex_mem_read = 0; ex_br_taken = 0; ex_br_target = 0;
    mem_rd_addr = 0; mem_reg_wr = 0; wb_rd_addr = 0; wb_reg_wr = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic settle; @(negedge clk); #1; endtask
  task automatic next;   @(posedge clk); #1; endtask

  initial begin
    rst = 1;
    clear_in();
    // Hazards presented during reset must not reach the outputs.
    ex_br_taken = 1; ex_br_target = 32'h100; ex_mem_read = 1; ex_rd_addr = 7; id_rs2_addr = 7;
    mem_reg_wr = 1; mem_rd_addr = 5; ex_rs1_addr = 5;
    settle();
    chk("rst_redirect", 32'(pc_redirect), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    next();
    clear_in();
    next();
    rst = 0;

    // Forwarding: MEM over WB, then x0, then WB-only.
    mem_reg_wr = 1; mem_rd_addr = 5; wb_reg_wr = 1; wb_rd_addr = 5; ex_rs1_addr = 5;
    settle(); chk("fwd_mem_prio", 32'(fwd_a_sel), 32'd1); chk("fwd_b_none", 32'(fwd_b_sel), 32'd0); next();
    mem_rd_addr = 0; wb_rd_addr = 0; ex_rs1_addr = 0;
    settle(); chk("fwd_x0", 32'(fwd_a_sel), 32'd0); next();
    mem_rd_addr = 3; wb_rd_addr = 5; ex_rs2_addr = 5;
    settle(); chk("fwd_wb", 32'(fwd_b_sel), 32'd2); next();
    clear_in();

    // Load-use on rs2.
    ex_mem_read = 1; ex_rd_addr = 7; id_rs2_addr = 7;
    settle(); chk("lu_pc_stall", 32'(pc_stall), 32'd1); chk("lu_id_ex_flush", 32'(id_ex_flush), 32'd1); next();
    clear_in();
    settle(); chk("lu_stall_cnt", stall_cnt, 32'd1); chk("lu_one_cycle", 32'(pc_stall), 32'd0); next();
    ex_mem_read = 1; ex_rd_addr = 0; id_rs1_addr = 0;
    settle(); chk("lu_x0", 32'(pc_stall), 32'd0); next();
    clear_in();

    // Taken branch, then branch overriding a load-use.
    ex_br_taken = 1; ex_br_target = 32'h100;
    settle(); chk("br_redirect", 32'(pc_redirect), 32'd1); chk("br_pc", redirect_pc, 32'h100);
    chk("br_if_id_flush", 32'(if_id_flush), 32'd1); next();
    ex_br_taken = 0;
    settle(); chk("br_flush_cnt", flush_cnt, 32'd1); chk("br_pc_idle", redirect_pc, 32'd0); next();
    ex_br_taken = 1; ex_mem_read = 1; ex_rd_addr = 7; id_rs2_addr = 7;
    settle(); chk("br_lu_pc_stall", 32'(pc_stall), 32'd0); chk("br_lu_flush", 32'(id_ex_flush), 32'd1); next();
    clear_in();

    // Memory wait with a pending branch.
    dmem_req = 1; ex_br_taken = 1; ex_br_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("mw_ex_mem_stall", 32'(ex_mem_stall), 32'd1); chk("mw_no_redirect", 32'(pc_redirect), 32'd0); next();
    end
    dmem_ready = 1;
    settle(); chk("mw_ready_stall", 32'(pc_stall), 32'd1); chk("mw_ready_no_redirect", 32'(pc_redirect), 32'd0); next();
    dmem_req = 0; dmem_ready = 0;
    settle(); chk("mw_after_redirect", 32'(pc_redirect), 32'd1); chk("mw_after_pc", redirect_pc, 32'h200);
    chk("mw_stall_cnt", stall_cnt, 32'd5); next();
    clear_in();

    // Ready arriving on the timeout cycle returns to RUN.
    dmem_req = 1;
    for (int i = 0; i < 5; i++) begin settle(); next(); end
    dmem_ready = 1;
    settle(); chk("edge_stall", 32'(pc_stall), 32'd1); next();
    clear_in();
    settle(); chk("edge_no_err", 32'(bus_err), 32'd0); chk("edge_run", 32'(pc_stall), 32'd0);
    chk("edge_stall_cnt", stall_cnt, 32'd11); next();

    // Timeout: one RUN-wait cycle plus five MEM_WAIT cycles, then sticky error.
    dmem_req = 1;
    for (int i = 0; i < 6; i++) begin
      settle(); chk("to_pending", 32'(bus_err), 32'd0); next();
    end
    settle(); chk("to_bus_err", 32'(bus_err), 32'd1); next();
    dmem_req = 0; ex_br_taken = 1; ex_br_target = 32'h300;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("err_stall", 32'(pc_stall), 32'd1); chk("err_no_redirect", 32'(pc_redirect), 32'd0); next();
    end
    clear_in();
    rst = 1;
    settle(); chk("err_rst_bus_err", 32'(bus_err), 32'd0); chk("err_rst_stall_cnt", stall_cnt, 32'd0);
    chk("err_rst_flush_cnt", flush_cnt, 32'd0); next();
    rst = 0;
    settle(); chk("err_release", 32'(pc_stall), 32'd0); next();

    // Reset in the middle of a memory wait.
    dmem_req = 1;
    settle(); next();
    settle(); next();
    rst = 1; dmem_req = 0;
    settle(); next();
    rst = 0;
    settle(); chk("mid_release", 32'(pc_stall), 32'd0); chk("mid_stall_cnt", stall_cnt, 32'd0); next();
    settle(); next();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
